// File: rtl/bsg_clk_gen_pearl_tag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_clk_gen_pearl_tag_sequencer
//  Description : Serializes parallel bsg_tag commands into tag packets that
//                program a bsg_clk_gen_pearl. After reset a master-reset
//                preamble of ones followed by a gap of zeros is emitted.
//                Each packet (LSB first per field) is:
//                  start(1) | len | data_not_reset | node_id | payload[len-1:0]
//                and is followed by a gap of zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_clk_gen_pearl_tag_sequencer #(
    parameter int ELS_P       = 16,
    parameter int LG_WIDTH_P  = 4,
    parameter int INIT_ONES_P = 32,
    parameter int GAP_P       = 4,
    localparam int c_ID_W     = (ELS_P > 1) ? $clog2(ELS_P) : 1,
    localparam int c_MAX_W    = (1 << LG_WIDTH_P) - 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    input  logic [c_ID_W-1:0]     node_id_i,
    input  logic                  data_not_reset_i,
    input  logic [LG_WIDTH_P-1:0] len_i,
    input  logic [c_MAX_W-1:0]    payload_i,
    output logic                  ready_o,
    output logic                  tag_data_o,
    output logic                  tag_en_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Header = start bit + length field + data/reset flag + node id.
    localparam int c_HDR_W      = 2 + LG_WIDTH_P + c_ID_W;
    localparam int c_PKT_W      = c_HDR_W + c_MAX_W;
    localparam int c_BIT_CNT_W  = (c_PKT_W > 0) ? $clog2(c_PKT_W + 1) : 1;
    localparam int c_INIT_CNT_W = $clog2(INIT_ONES_P + 1);
    localparam int c_GAP_CNT_W  = $clog2(GAP_P + 1);
    // One counter serves the preamble, the gap and the packet bit count, so
    // it is sized for whichever of them is longest.
    localparam int c_CNT_W0     = (c_BIT_CNT_W > c_INIT_CNT_W) ? c_BIT_CNT_W : c_INIT_CNT_W;
    localparam int c_CNT_W      = (c_CNT_W0 > c_GAP_CNT_W) ? c_CNT_W0 : c_GAP_CNT_W;

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_GAP  = 2'd1;
    localparam logic [1:0] c_ST_IDLE = 2'd2;
    localparam logic [1:0] c_ST_SEND = 2'd3;

    localparam logic [c_CNT_W-1:0] c_INIT_CNT = c_CNT_W'(INIT_ONES_P);
    localparam logic [c_CNT_W-1:0] c_GAP_CNT  = c_CNT_W'(GAP_P);
    localparam logic [c_CNT_W-1:0] c_HDR_CNT  = c_CNT_W'(c_HDR_W);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT  = c_CNT_W'(1);

    // With no gap configured, preamble and packets fall straight into IDLE.
    localparam logic [1:0]         c_ST_AFTER  = (GAP_P == 0) ? c_ST_IDLE : c_ST_GAP;
    localparam logic [c_CNT_W-1:0] c_CNT_AFTER = (GAP_P == 0) ? '0 : c_ONE_CNT;

    // r_cnt counts cycles already emitted in the current state; r_pkt_len is
    // the total bit count of the packet in flight.
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_pkt_len;
    logic [c_PKT_W-1:0] r_shreg;
    logic               r_tag_data;
    logic               r_tag_en;
    logic               r_done;

    logic [1:0]         w_state_n;
    logic [c_CNT_W-1:0] w_cnt_n;
    logic [c_CNT_W-1:0] w_pkt_len_n;
    logic [c_PKT_W-1:0] w_shreg_n;
    logic               w_data_n;
    logic               w_done_n;
    logic [c_PKT_W-1:0] w_pkt;
    logic [c_CNT_W-1:0] w_pkt_len;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign ready_o    = (r_state == c_ST_IDLE);
    assign busy_o     = (r_state != c_ST_IDLE);
    assign tag_data_o = r_tag_data;
    assign tag_en_o   = r_tag_en;
    assign done_o     = r_done;

    // Next-state and next-output decode; outputs are registered so each
    // branch decides the bit that will be on the wire during the next cycle.
    always_comb begin
        w_pkt       = {payload_i, node_id_i, data_not_reset_i, len_i, 1'b1};
        w_pkt_len   = c_HDR_CNT + c_CNT_W'(len_i);
        w_cnt_inc   = r_cnt + c_ONE_CNT;
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_pkt_len_n = r_pkt_len;
        w_shreg_n   = r_shreg;
        w_data_n    = 1'b0;
        w_done_n    = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                if (r_cnt == c_INIT_CNT) begin
                    w_state_n = c_ST_AFTER;
                    w_cnt_n   = c_CNT_AFTER;
                end else begin
                    w_cnt_n  = w_cnt_inc;
                    w_data_n = 1'b1;
                end
            end
            c_ST_GAP: begin
                if (r_cnt == c_GAP_CNT) begin
                    w_state_n = c_ST_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            c_ST_IDLE: begin
                // Start bit goes out in the cycle right after acceptance.
                if (v_i && ready_o) begin
                    w_state_n   = c_ST_SEND;
                    w_cnt_n     = c_ONE_CNT;
                    w_pkt_len_n = w_pkt_len;
                    w_data_n    = w_pkt[0];
                    w_shreg_n   = w_pkt >> 1;
                    w_done_n    = (w_pkt_len == c_ONE_CNT);
                end
            end
            c_ST_SEND: begin
                if (r_cnt == r_pkt_len) begin
                    w_state_n = c_ST_AFTER;
                    w_cnt_n   = c_CNT_AFTER;
                end else begin
                    w_data_n  = r_shreg[0];
                    w_shreg_n = r_shreg >> 1;
                    w_cnt_n   = w_cnt_inc;
                    w_done_n  = (w_cnt_inc == r_pkt_len);
                end
            end
            default: begin
                w_state_n = c_ST_INIT;
                w_cnt_n   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any packet and restarts the
    // preamble, which also clears a truncated packet at the receiver.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= c_ST_INIT;
            r_cnt      <= '0;
            r_pkt_len  <= '0;
            r_shreg    <= '0;
            r_tag_data <= 1'b0;
            r_tag_en   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_pkt_len  <= w_pkt_len_n;
            r_shreg    <= w_shreg_n;
            r_tag_data <= w_data_n;
            r_tag_en   <= 1'b1;
            r_done     <= w_done_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_clk_gen_pearl_tag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_clk_gen_pearl_tag_sequencer
//  Description : Self-checking bench for bsg_clk_gen_pearl_tag_sequencer.
//                Expected serial bits are pushed into a scoreboard queue when
//                a command is driven and popped as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_clk_gen_pearl_tag_sequencer;

    localparam int LG_W  = 4;
    localparam int ID_W  = 4;
    localparam int MAX_W = 15;
    localparam int GAP   = 4;
    localparam int INIT  = 32;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             v_i = 1'b0;
    logic [ID_W-1:0]  node_id = '0;
    logic             dnr = 1'b0;
    logic [LG_W-1:0]  len = '0;
    logic [MAX_W-1:0] payload = '0;
    logic             ready_o;
    logic             tag_data_o;
    logic             tag_en_o;
    logic             busy_o;
    logic             done_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic data;
        logic done;
        logic ready;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bsg_clk_gen_pearl_tag_sequencer dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .node_id_i        (node_id),
        .data_not_reset_i (dnr),
        .len_i            (len),
        .payload_i        (payload),
        .ready_o          (ready_o),
        .tag_data_o       (tag_data_o),
        .tag_en_o         (tag_en_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    // Reference packet: each field LSB first, payload truncated to len bits.
    task automatic push_packet(input logic [ID_W-1:0] n, input logic d,
                               input logic [LG_W-1:0] l, input logic [MAX_W-1:0] p);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b1);
        for (int i = 0; i < LG_W; i++) bits.push_back(l[i]);
        bits.push_back(d);
        for (int i = 0; i < ID_W; i++) bits.push_back(n[i]);
        for (int i = 0; i < int'(l); i++) bits.push_back(p[i]);
        for (int i = 0; i < bits.size(); i++) begin
            e.data  = bits[i];
            e.done  = (i == bits.size() - 1);
            e.ready = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic push_gap_idle();
        exp_t e;
        for (int i = 0; i < GAP; i++) begin
            e = '{data: 1'b0, done: 1'b0, ready: 1'b0};
            sb.push_back(e);
        end
        e = '{data: 1'b0, done: 1'b0, ready: 1'b1};
        sb.push_back(e);
    endtask

    // Pops one expected entry per cycle; v_i is dropped after entry drop_at.
    task automatic sb_drain(input int drop_at);
        int   idx = 0;
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (tag_data_o !== e.data) begin
                n_fail++;
                $display("FAIL sb_data[%0d]: got %b expected %b", idx, tag_data_o, e.data);
            end
            n_tests++;
            if (done_o !== e.done) begin
                n_fail++;
                $display("FAIL sb_done[%0d]: got %b expected %b", idx, done_o, e.done);
            end
            n_tests++;
            if (ready_o !== e.ready) begin
                n_fail++;
                $display("FAIL sb_ready[%0d]: got %b expected %b", idx, ready_o, e.ready);
            end
            n_tests++;
            if (tag_en_o !== 1'b1) begin
                n_fail++;
                $display("FAIL sb_en[%0d]: got %b expected 1", idx, tag_en_o);
            end
            if (idx == drop_at) v_i = 1'b0;
            idx++;
        end
    endtask

    task automatic wait_ready(input string tag);
        int waited = 0;
        while (ready_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_wait: got %b expected 1", tag, ready_o);
        end
    endtask

    task automatic run_cmd(input logic [ID_W-1:0] n, input logic d,
                           input logic [LG_W-1:0] l, input logic [MAX_W-1:0] p);
        wait_ready("cmd");
        node_id = n; dnr = d; len = l; payload = p;
        v_i = 1'b1;
        push_packet(n, d, l, p);
        push_gap_idle();
        sb_drain(0);
    endtask

    // Entered at a negedge with reset_i high; releases reset and checks the
    // preamble, gap and first IDLE cycles. hold_v keeps v_i high until IDLE.
    task automatic check_preamble(input logic hold_v);
        reset_i = 1'b0;
        v_i = hold_v;
        for (int k = 1; k <= INIT + GAP; k++) begin
            @(negedge clk);
            n_tests++;
            if (tag_en_o !== 1'b1 || tag_data_o !== (k <= INIT)) begin
                n_fail++;
                $display("FAIL pre_bit[%0d]: got en=%b data=%b expected en=1 data=%b",
                         k, tag_en_o, tag_data_o, (k <= INIT));
            end
            n_tests++;
            if (ready_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL pre_ctl[%0d]: got ready=%b busy=%b done=%b expected 0 1 0",
                         k, ready_o, busy_o, done_o);
            end
            if (k == INIT + GAP) v_i = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (ready_o !== 1'b1 || busy_o !== 1'b0 || tag_data_o !== 1'b0 || tag_en_o !== 1'b1) begin
                n_fail++;
                $display("FAIL pre_idle[%0d]: got ready=%b busy=%b data=%b en=%b expected 1 0 0 1",
                         k, ready_o, busy_o, tag_data_o, tag_en_o);
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        v_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (tag_en_o !== 1'b0 || tag_data_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_serial: got en=%b data=%b expected 0 0", tag_en_o, tag_data_o);
        end
        n_tests++;
        if (ready_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got ready=%b busy=%b done=%b expected 0 1 0",
                     ready_o, busy_o, done_o);
        end
        check_preamble(1'b0);
    endtask

    task automatic test_basic();
        run_cmd(4'd3, 1'b1, 4'd5, 15'h0015);
    endtask

    task automatic test_len_zero();
        run_cmd(4'd15, 1'b0, 4'd0, 15'h7FFF);
    endtask

    task automatic test_len_max();
        run_cmd(4'd0, 1'b1, 4'd15, 15'h7FFF);
    endtask

    task automatic test_random();
        logic [ID_W-1:0]  n;
        logic [LG_W-1:0]  l;
        logic [MAX_W-1:0] p;
        logic             d;
        for (int i = 0; i < 4; i++) begin
            n = ID_W'($urandom_range(0, 15));
            l = LG_W'($urandom_range(0, 15));
            p = MAX_W'($urandom);
            d = 1'($urandom_range(0, 1));
            run_cmd(n, d, l, p);
        end
    endtask

    // v_i stays high across two commands; the second must wait for GAP+IDLE.
    task automatic test_back_to_back();
        int   idx = 0;
        int   a_total;
        exp_t e;
        wait_ready("b2b");
        node_id = 4'd5; dnr = 1'b1; len = 4'd3; payload = 15'h0005;
        v_i = 1'b1;
        push_packet(4'd5, 1'b1, 4'd3, 15'h0005);
        push_gap_idle();
        a_total = sb.size();
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (tag_data_o !== e.data || done_o !== e.done || ready_o !== e.ready) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got data=%b done=%b ready=%b expected %b %b %b",
                         idx, tag_data_o, done_o, ready_o, e.data, e.done, e.ready);
            end
            if (idx == 0) begin
                node_id = 4'd10; dnr = 1'b0; len = 4'd2; payload = 15'h0003;
                push_packet(4'd10, 1'b0, 4'd2, 15'h0003);
                push_gap_idle();
            end
            if (idx == a_total) v_i = 1'b0;
            idx++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (tag_data_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_once[%0d]: got data=%b ready=%b busy=%b expected 0 1 0",
                         k, tag_data_o, ready_o, busy_o);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        exp_t e;
        wait_ready("abort");
        node_id = 4'd3; dnr = 1'b1; len = 4'd5; payload = 15'h0015;
        v_i = 1'b1;
        push_packet(4'd3, 1'b1, 4'd5, 15'h0015);
        for (int idx = 0; idx < 7; idx++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (tag_data_o !== e.data || done_o !== e.done) begin
                n_fail++;
                $display("FAIL abort_bit[%0d]: got data=%b done=%b expected %b %b",
                         idx, tag_data_o, done_o, e.data, e.done);
            end
            if (idx == 0) v_i = 1'b0;
        end
        reset_i = 1'b1;
        sb.delete();
        @(negedge clk);
        n_tests++;
        if (tag_en_o !== 1'b0 || tag_data_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: got en=%b data=%b done=%b expected 0 0 0",
                     tag_en_o, tag_data_o, done_o);
        end
        n_tests++;
        if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ctl: got ready=%b busy=%b expected 0 1", ready_o, busy_o);
        end
        check_preamble(1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_len_max();
        test_back_to_back();
        test_random();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bsg_clk_gen_pearl_tag_sequencer.md
Name: bsg_clk_gen_pearl_tag_sequencer

Overview:
Sequencer that programs a bsg_clk_gen_pearl over its serial bsg_tag interface. Accepts parallel tag commands (node id, data/reset flag, length, payload) on a valid/ready port and serializes each into a bsg_tag packet on tag_data_o/tag_en_o. After reset it first emits the master-reset preamble. Sits on the PCB/board-controller side and drives the pearl's tag_clk_i/tag_data_i; tag_clk_i is clk_i.

Parameters:
els_p, 16, number of tag clients; node id width id_w = `BSG_SAFE_CLOG2(els_p)
lg_width_p, 4, length-field width; max payload bits max_w = 2^lg_width_p - 1
init_ones_p, 32, cycles of '1' emitted after reset (tag master reset preamble)
gap_p, 4, cycles of '0' after preamble and after every packet

Ports:
clk_i  in  1  clock; also the tag serial clock
reset_i  in  1  synchronous, active-high reset
v_i  in  1  command valid
node_id_i  in  id_w  target tag client
data_not_reset_i  in  1  1 = data packet, 0 = client reset packet
len_i  in  lg_width_p  payload bit count, 0..max_w
payload_i  in  max_w  payload; bits at index >= len_i ignored
ready_o  out  1  command accepted when v_i & ready_o
tag_data_o  out  1  serial tag bit
tag_en_o  out  1  tag drive enable (pearl input is tag_data & tag_en)
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse on last serial bit of a packet

Behaviour:
- Reset (reset_i=1 sampled at clk edge): state=INIT, counter=0; tag_data_o=0, tag_en_o=0, ready_o=0, busy_o=1, done_o=0. All outputs registered.
- INIT: init_ones_p cycles with tag_en_o=1, tag_data_o=1; then GAP.
- GAP: gap_p cycles with tag_en_o=1, tag_data_o=0; then IDLE. gap_p=0: go directly to IDLE.
- IDLE: ready_o=1, busy_o=0, tag_en_o=1, tag_data_o=0. On v_i & ready_o: capture all fields into a shift register, go to SEND. First packet bit appears on tag_data_o the cycle after acceptance.
- ready_o is a combinational decode of state==IDLE and is independent of v_i. v_i may drop without acceptance; no command is held.
- SEND: serial order, each field LSB first: start bit 1; len (lg_width_p bits); data_not_reset (1); node_id (id_w); payload[len-1:0]. Total bits = 2 + lg_width_p + id_w + len. tag_en_o=1. done_o=1 coincident with the final bit. Then GAP, then IDLE.
- len_i=0: header only, with done_o on the node_id MSB.
- Bit counter width: `BSG_SAFE_CLOG2(2+lg_width_p+id_w+max_w+1). No wrap within a packet.
- ready_o=0 in INIT/GAP/SEND. Commands presented then are not consumed.
- reset_i mid-SEND: packet aborted immediately, outputs take reset values next cycle, preamble re-emitted. The truncated packet is cleared by the preamble.
- Back-to-back commands: minimum spacing between packet starts = packet bits + gap_p + 1 cycles (1 IDLE cycle).

Test Plan:
- Reset release, init_ones_p=32, gap_p=4: tag_en_o rises cycle 1; tag_data_o=1 for exactly 32 cycles, 0 for 4; ready_o=1 from the 37th cycle.
- Defaults, command node=3, dnr=1, len=5, payload=0x15: tag_data_o over 15 cycles = 1,1,0,1,0,1,1,1,0,0,1,0,1,0,1. done_o on cycle 15. ready_o returns after 4 gap cycles + 1.
- len=0, node=15, dnr=0: 10 bits 1,0,0,0,0,0,1,1,1,1. done_o on the 10th bit. Payload_i=all ones is not emitted.
- len=15, payload=0x7FFF, node=0: 25 bits, last 15 all 1. Payload bit 14 is sent.
- v_i held high continuously with two commands: second accepted only after GAP+IDLE. No bit overlap. Each command emitted exactly once.
- reset_i asserted at bit 7 of a 15-bit packet: next cycle tag_en_o=0, tag_data_o=0. After release, full 32-one preamble; the aborted command is not resent.
